// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule that expands forward to round 10, then walks the
// schedule backwards to emit round keys in decryption order (10 down to 0).
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     round_q, round_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sbox_in, rot_word, sub_word, temp;
  logic [3:0]  rcon_idx;
  logic [127:0] fwd_rk, inv_rk;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];

  // The inverse step needs SubWord of the recovered previous w3, so the single
  // S-box bank is fed from w3^w2 while emitting and from w3 while expanding.
  assign sbox_in  = (state_q == EMIT) ? (w3 ^ w2) : w3;
  assign rot_word = {sbox_in[23:0], sbox_in[31:24]};
  assign rcon_idx = (state_q == EMIT) ? round_q : cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
    end
  endgenerate

  assign temp = sub_word ^ {rcon(rcon_idx), 24'h0};

  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    f0 = w0 ^ temp;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    fwd_rk = {f0, f1, f2, f3};
    inv_rk = {w0 ^ temp, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = key;
          cnt_d   = 4'd1;
          round_d = 4'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d = fwd_rk;
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          round_d = 4'd10;
          valid_d = 1'b1;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EMIT: begin
        if (valid_q && rk_ready) begin
          if (round_q == 4'd0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rk_d    = inv_rk;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_out   = rk_q;
  assign rk_round = round_q;
  assign rk_valid = valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched: FIPS-197 key, zero key, backpressure,
// ignored starts, start in the done cycle and reset during emission.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] exp_a [0:10];

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rk_out"}, rk_out, 128'h0);
    check({tag, "_rk_round"}, 128'(rk_round), 128'h0);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'h0);
    check({tag, "_busy"}, 128'(busy), 128'h0);
    check({tag, "_done"}, 128'(done), 128'h0);
  endtask

  // Called at a negedge; drives start for exactly one rising edge.
  task automatic start_sched(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    key   = ~k;
    check("start_busy", 128'(busy), 128'h1);
    check("start_done_low", 128'(done), 128'h0);
  endtask

  task automatic expand_phase(input bit noise);
    int early;
    early = 0;
    for (int i = 1; i <= 10; i++) begin
      if (noise && i == 3) begin
        start = 1'b1;
        key   = 128'h0;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (i < 10 && rk_valid !== 1'b0) early++;
    end
    check("expand_no_early_valid", 128'(early), 128'h0);
    check("valid_after_10_edges", 128'(rk_valid), 128'h1);
    check("first_round_10", 128'(rk_round), 128'd10);
  endtask

  task automatic emit_phase(input int sel, input bit bp, input bit noise, input int stop_round);
    int r;
    int cyc;
    bit fin;
    r = 10;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      check("emit_valid", 128'(rk_valid), 128'h1);
      check("emit_round", 128'(rk_round), 128'(r));
      if (sel == 0) check("rk_key_a", rk_out, exp_a[r]);
      else if (r == 10) check("rk_zero_r10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      else if (r == 1) check("rk_zero_r1", rk_out, 128'h62636363626363636263636362636363);
      else if (r == 0) check("rk_zero_r0", rk_out, 128'h0);
      if (r == stop_round) return;
      rk_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (noise) begin
        start = (r == 5);
        key   = 128'h0;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (rk_ready) begin
        if (r == 0) fin = 1'b1;
        else r--;
      end
    end
    rk_ready = 1'b0;
    check("emit_completed", 128'(fin), 128'h1);
    check("done_pulse", 128'(done), 128'h1);
    check("done_valid_low", 128'(rk_valid), 128'h0);
    check("done_not_busy", 128'(busy), 128'h0);
  endtask

  initial begin
    int spur;
    exp_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    key = 128'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, consumer always ready
    start_sched(KEY_A);
    expand_phase(1'b0);
    emit_phase(0, 1'b0, 1'b0, -1);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'h0);
    check("idle_after_done_valid", 128'(rk_valid), 128'h0);

    // Random backpressure
    start_sched(KEY_A);
    expand_phase(1'b0);
    emit_phase(0, 1'b1, 1'b0, -1);

    // Start accepted in the done cycle, zero key
    start_sched(128'h0);
    expand_phase(1'b0);
    emit_phase(1, 1'b0, 1'b0, -1);

    // Starts while busy are ignored
    @(negedge clk);
    start_sched(KEY_A);
    expand_phase(1'b1);
    emit_phase(0, 1'b0, 1'b1, -1);

    // Reset while round 6 is presented
    @(negedge clk);
    start_sched(KEY_A);
    expand_phase(1'b0);
    emit_phase(0, 1'b0, 1'b0, 6);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_emit");
    #2;
    rst = 1'b0;
    rk_ready = 1'b1;
    @(negedge clk);
    spur = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (rk_valid !== 1'b0 || busy !== 1'b0) spur++;
    end
    check("no_valid_after_rst", 128'(spur), 128'h0);
    start_sched(KEY_A);
    expand_phase(1'b0);
    emit_phase(0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
- Parameters: none.
- REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
- REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-high.
- REQ-003 start  in  1  request to begin a schedule for key; sampled only in IDLE.
- REQ-004 key  in  128  AES-128 cipher key; word w0 = key[127:96], w3 = key[31:0].
- REQ-005 busy  out  1  high in every state except IDLE.
- REQ-006 rk_out  out  128  current round key, same word order as key.
- REQ-007 rk_round  out  4  round index of rk_out, 0..10.
- REQ-008 rk_valid  out  1  rk_out/rk_round valid for consumer.
- REQ-009 rk_ready  in  1  consumer accepts rk_out when rk_valid & rk_ready at a rising edge.
- REQ-010 done  out  1  one-cycle pulse after round key 0 is accepted.

Function
- REQ-011 SHALL deliver round keys in decryption order: 10, 9, ..., 0, one per handshake.
- REQ-012 SHALL implement states IDLE, EXPAND, EMIT.
- REQ-013 IDLE: start=1 at an edge -> capture key into rk register, counter=1, go to EXPAND; start=0 -> stay.
- REQ-014 EXPAND: each edge applies forward round counter: temp = SubWord(RotWord(w3)) ^ {Rcon[counter],24'h0}; w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; counter increments.
- REQ-015 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- REQ-016 On the edge applying round 10 SHALL move to EMIT with rk_round=10, rk_valid=1; rk_valid therefore rises exactly 10 clock edges after the start-sampling edge.
- REQ-017 EMIT, handshake with rk_round=r>0: next edge rk_out becomes round r-1 via inverse step w3=w3'^w2', w2=w2'^w1', w1=w1'^w0', w0=w0'^SubWord(RotWord(w3))^{Rcon[r],24'h0}; rk_round=r-1; rk_valid stays 1 (one key per cycle when rk_ready held high).
- REQ-018 EMIT, rk_valid=1 and rk_ready=0: rk_out, rk_round, rk_valid SHALL hold unchanged.
- REQ-019 EMIT, handshake with rk_round=0: next edge rk_valid=0, done=1 for exactly one cycle, state IDLE.
- REQ-020 start while busy=1 SHALL be ignored with no effect on state or key.
- REQ-021 start in the cycle done=1 SHALL be accepted (state is IDLE).
- REQ-022 key SHALL be sampled only at the start-accepting edge; later changes have no effect.
- REQ-023 rk_out SHALL always equal the internal round-key register (intermediate values visible during EXPAND; rk_valid=0 then).
- REQ-024 SubWord SHALL use the FIPS-197 forward S-box (four instances, combinational); no other arithmetic beyond XOR.
- REQ-025 rk_valid SHALL never be 1 outside EMIT; rk_round SHALL never exceed 10.

Reset
- REQ-026 rst=1 SHALL asynchronously force IDLE, rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0, counter=0.
- REQ-027 rst asserted mid-EXPAND or mid-EMIT SHALL abandon the schedule; after release no rk_valid until a new start.

Verification
- REQ-028 key=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle, rk_ready=1 -> rk_valid rises 10 edges later; rk_out sequence d014f9a8c9ee2589e13f0cc8b6630ca6 (r10), ac7766f319fadc2128d12941575c006e (r9), ..., a0fafe1788542cb123a339392a6c7605 (r1), 2b7e1516...4f3c (r0) on 11 consecutive cycles, then done=1 one cycle.
- REQ-029 key=0, rk_ready=1 -> first rk_out b4ef5bcb3e92e21123e951cf6f8f188e with rk_round=10; last rk_out 0 with rk_round=0.
- REQ-030 Backpressure: rk_ready random 30% duty -> same 11-key sequence, rk_out/rk_round stable whenever valid & !ready, no key skipped or repeated.
- REQ-031 start pulsed during EXPAND and EMIT with a different key -> output sequence unchanged; start in done cycle -> new schedule, rk_valid 10 edges later.
- REQ-032 rst asserted at rk_round=6 -> all outputs 0 immediately; after release rk_valid stays 0 until start; subsequent run matches REQ-028.
